// File: rtl/lut_table.sv
// Keyed lookup table with a sequential one-entry-per-cycle search.
// Lowest matching valid entry wins; a miss returns the captured default.
module lut_table #(
  parameter int NR_KEY   = 8,
  parameter int KEY_LEN  = 8,
  parameter int DATA_LEN = 32,
  localparam int IW      = $clog2(NR_KEY)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wen,
  input  logic [IW-1:0]       widx,
  input  logic [KEY_LEN-1:0]  wkey,
  input  logic [DATA_LEN-1:0] wdata,
  input  logic                clr,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [KEY_LEN-1:0]  req_key,
  input  logic [DATA_LEN-1:0] req_default,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_LEN-1:0] resp_data,
  output logic                resp_hit,
  output logic [IW-1:0]       resp_idx
);

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    RESP
  } state_t;

  state_t state;
  state_t state_d;

  logic [NR_KEY-1:0]   vld;
  logic [KEY_LEN-1:0]  keys [NR_KEY];
  logic [DATA_LEN-1:0] data [NR_KEY];

  logic [IW-1:0]       scan;
  logic [KEY_LEN-1:0]  cap_key;
  logic [DATA_LEN-1:0] cap_def;
  logic [DATA_LEN-1:0] out_data;
  logic                out_hit;
  logic [IW-1:0]       out_idx;

  logic match;
  logic last;

  assign match = vld[scan] && (keys[scan] == cap_key);
  assign last  = (scan == IW'(NR_KEY - 1));

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (req_valid) state_d = SEARCH;
      SEARCH:  if (match || last) state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Table updates are independent of the lookup FSM; clr beats wen.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < NR_KEY; i++) begin
        keys[i] <= '0;
        data[i] <= '0;
      end
    end else if (clr) begin
      vld <= '0;
    end else if (wen) begin
      vld[widx]  <= 1'b1;
      keys[widx] <= wkey;
      data[widx] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan     <= '0;
      cap_key  <= '0;
      cap_def  <= '0;
      out_data <= '0;
      out_hit  <= 1'b0;
      out_idx  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            cap_key <= req_key;
            cap_def <= req_default;
            scan    <= '0;
          end
        end
        SEARCH: begin
          if (match) begin
            out_data <= data[scan];
            out_hit  <= 1'b1;
            out_idx  <= scan;
          end else if (last) begin
            out_data <= cap_def;
            out_hit  <= 1'b0;
            out_idx  <= '0;
          end else begin
            scan <= scan + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are forced low for the whole time reset is held.
  assign req_ready  = (state == IDLE) && !rst;
  assign resp_valid = (state == RESP) && !rst;
  assign resp_data  = rst ? '0 : out_data;
  assign resp_hit   = rst ? 1'b0 : out_hit;
  assign resp_idx   = rst ? '0 : out_idx;

endmodule

// File: tb/tb_lut_table.sv
// Scoreboard bench for lut_table: the driver queues expected responses,
// the monitor pops and checks them when resp_valid appears.
module tb_lut_table;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wen = 1'b0;
  logic [2:0]  widx = '0;
  logic [7:0]  wkey = '0;
  logic [31:0] wdata = '0;
  logic        clr = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_key = '0;
  logic [31:0] req_default = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_data;
  logic        resp_hit;
  logic [2:0]  resp_idx;

  lut_table #(
    .NR_KEY(8),
    .KEY_LEN(8),
    .DATA_LEN(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wen(wen),
    .widx(widx),
    .wkey(wkey),
    .wdata(wdata),
    .clr(clr),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_key(req_key),
    .req_default(req_default),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data(resp_data),
    .resp_hit(resp_hit),
    .resp_idx(resp_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        hit;
    logic [2:0]  idx;
    int          at;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   active = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Monitor samples just after the falling edge, after driver updates.
  always @(negedge clk) begin
    #1;
    if (resp_valid) begin
      if (!active) begin
        if (q.size() == 0) begin
          chk("unexpected_resp", 64'(resp_valid), 64'd0);
        end else begin
          cur = q.pop_front();
          active = 1;
          chk("resp_cycle", 64'(cyc), 64'(cur.at));
        end
      end
      if (active) begin
        chk("resp_data", 64'(resp_data), 64'(cur.data));
        chk("resp_hit", 64'(resp_hit), 64'(cur.hit));
        chk("resp_idx", 64'(resp_idx), 64'(cur.idx));
        chk("req_ready_in_resp", 64'(req_ready), 64'd0);
        if (resp_ready) active = 0;
      end
    end
  end

  task automatic wr(input logic [2:0] i, input logic [7:0] k,
                    input logic [31:0] d);
    @(negedge clk);
    wen = 1'b1; widx = i; wkey = k; wdata = d;
    @(negedge clk);
    wen = 1'b0;
  endtask

  // Issue one request; optionally queue its expected response.
  task automatic issue(input logic [7:0] k, input logic [31:0] def,
                       input bit push, input logic [31:0] ed,
                       input logic eh, input logic [2:0] ei,
                       input int lat);
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1; req_key = k; req_default = def;
    for (int n = 0; n < 50 && !req_ready; n++) @(negedge clk);
    if (!req_ready) begin
      chk("req_ready_timeout", 64'(req_ready), 64'd1);
    end else if (push) begin
      e.data = ed; e.hit = eh; e.idx = ei; e.at = cyc + lat;
      q.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || active || resp_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("drain_timeout", 64'(q.size()), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_data", 64'(resp_data), 64'd0);
    chk("rst_resp_hit", 64'(resp_hit), 64'd0);
    chk("rst_resp_idx", 64'(resp_idx), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", 64'(req_ready), 64'd1);

    // Empty table: full-length miss returns the default.
    issue(8'h11, 32'h12345678, 1, 32'h12345678, 1'b0, 3'd0, 9);
    drain();

    // Single hit at entry 3.
    wr(3'd3, 8'h5A, 32'hDEADBEEF);
    issue(8'h5A, 32'h0, 1, 32'hDEADBEEF, 1'b1, 3'd3, 5);
    drain();

    // Duplicate key: lowest index wins.
    wr(3'd1, 8'h22, 32'h0000_00A1);
    wr(3'd6, 8'h22, 32'h0000_00B6);
    issue(8'h22, 32'hFFFF_FFFF, 1, 32'h0000_00A1, 1'b1, 3'd1, 3);
    drain();

    // Hit at the last entry.
    wr(3'd7, 8'h99, 32'h7777_0007);
    issue(8'h99, 32'h0, 1, 32'h7777_0007, 1'b1, 3'd7, 9);
    drain();

    // Backpressure: hold resp_ready low for 4 cycles.
    resp_ready = 1'b0;
    issue(8'h5A, 32'h0, 1, 32'hDEADBEEF, 1'b1, 3'd3, 5);
    for (int n = 0; n < 20 && !resp_valid; n++) @(negedge clk);
    chk("stall_valid_seen", 64'(resp_valid), 64'd1);
    repeat (4) @(negedge clk);
    chk("stall_valid_held", 64'(resp_valid), 64'd1);
    resp_ready = 1'b1;
    @(negedge clk);
    chk("stall_idle_after", 64'(req_ready), 64'd1);
    chk("stall_valid_drop", 64'(resp_valid), 64'd0);
    drain();

    // clr beats a simultaneous write.
    @(negedge clk);
    wen = 1'b1; clr = 1'b1; widx = 3'd0; wkey = 8'h77; wdata = 32'h1;
    @(negedge clk);
    wen = 1'b0; clr = 1'b0;
    issue(8'h77, 32'hABCD0001, 1, 32'hABCD0001, 1'b0, 3'd0, 9);
    drain();
    issue(8'h5A, 32'hABCD0002, 1, 32'hABCD0002, 1'b0, 3'd0, 9);
    drain();

    // Reset mid-search aborts the lookup and wipes the table.
    wr(3'd2, 8'h33, 32'h3333_3333);
    issue(8'h33, 32'h0, 0, 32'h0, 1'b0, 3'd0, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_resp_valid", 64'(resp_valid), 64'd0);
    chk("abort_resp_data", 64'(resp_data), 64'd0);
    chk("abort_resp_hit", 64'(resp_hit), 64'd0);
    chk("abort_resp_idx", 64'(resp_idx), 64'd0);
    chk("abort_req_ready", 64'(req_ready), 64'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_no_resp", 64'(resp_valid), 64'd0);
    issue(8'h33, 32'h0000_CAFE, 1, 32'h0000_CAFE, 1'b0, 3'd0, 9);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lut_table.md
LUT_TABLE -- requirements
Module: ysyx_25040118_LutTable

Interface
REQ-001 SHALL take parameter NR_KEY, default 8: number of table entries, power of two, at least 2.
REQ-002 SHALL take parameter KEY_LEN, default 8: key width.
REQ-003 SHALL take parameter DATA_LEN, default 32: data width.
REQ-004 SHALL use one clock and a synchronous, active-high reset, with ports named clk and rst as in the codebase.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-007 SHALL have port wen, input, 1 bit: table write strobe.
REQ-008 SHALL have port widx, input, $clog2(NR_KEY) bits: index of the entry to write.
REQ-009 SHALL have port wkey, input, KEY_LEN bits: key written to the entry.
REQ-010 SHALL have port wdata, input, DATA_LEN bits: data written to the entry.
REQ-011 SHALL have port clr, input, 1 bit: invalidate all entries.
REQ-012 SHALL have port req_valid, input, 1 bit: lookup request valid.
REQ-013 SHALL have port req_ready, output, 1 bit: lookup request accepted.
REQ-014 SHALL have port req_key, input, KEY_LEN bits: key to look up.
REQ-015 SHALL have port req_default, input, DATA_LEN bits: value returned on a miss.
REQ-016 SHALL have port resp_valid, output, 1 bit: response valid.
REQ-017 SHALL have port resp_ready, input, 1 bit: response consumed.
REQ-018 SHALL have port resp_data, output, DATA_LEN bits: matched data, or the captured default on a miss.
REQ-019 SHALL have port resp_hit, output, 1 bit: 1 = key matched a valid entry.
REQ-020 SHALL have port resp_idx, output, $clog2(NR_KEY) bits: matching entry index; 0 on a miss.

Function
REQ-021 SHALL hold NR_KEY entries, each consisting of a valid bit, a key and data.
REQ-022 SHALL, when wen=1 and clr=0, write {valid=1, wkey, wdata} into entry widx at the clock edge.
REQ-023 SHALL, when clr=1, clear every valid bit at the clock edge; clr overrides a wen in the same cycle.
REQ-024 SHALL accept table writes and clears in any FSM state.
REQ-025 SHALL implement three states: IDLE, SEARCH and RESP.
REQ-026 SHALL drive req_ready=1 only in IDLE while rst=0.
REQ-027 SHALL, in IDLE when req_valid=1, capture req_key and req_default, clear the scan index to 0, and move to SEARCH.
REQ-028 SHALL, in SEARCH, compare exactly one entry per cycle (entry at the scan index) using the table contents before that cycle's clock edge.
REQ-029 SHALL, on a match with a valid entry, latch resp_data=entry data, resp_hit=1 and resp_idx=the scan index, then move to RESP.
REQ-030 SHALL, on no match at index NR_KEY-1, latch resp_data=captured default, resp_hit=0 and resp_idx=0, then move to RESP.
REQ-031 SHALL otherwise increment the scan index and remain in SEARCH; the lowest matching index wins.
REQ-032 SHALL not rescan an entry written after the scan index has passed it.
REQ-033 SHALL drive resp_valid=1 in RESP and hold resp_data, resp_hit and resp_idx stable until resp_ready=1, then return to IDLE.
REQ-034 SHALL not accept a new request in the cycle in which the response handshakes.
REQ-035 SHALL meet this latency: request handshake in cycle T gives resp_valid high at T+2+i for a hit at entry i, and at T+1+NR_KEY for a miss.

Reset
REQ-036 SHALL, while rst=1, clear all valid bits and set all keys and data to 0.
REQ-037 SHALL, while rst=1, enter IDLE and drive req_ready=0, resp_valid=0, resp_data=0, resp_hit=0 and resp_idx=0.
REQ-038 SHALL, when reset occurs mid-SEARCH or mid-RESP, abort the lookup with no response produced afterwards.
REQ-039 SHALL take reset priority over wen, clr and every handshake.

Verification
REQ-040 SHALL cover: write entry 3 with key 0x5A and data 0xDEADBEEF, then look up 0x5A -> resp_hit=1, resp_idx=3, resp_data=0xDEADBEEF, resp_valid high 5 cycles after the handshake.
REQ-041 SHALL cover: empty table, look up 0x11 with default 0x12345678 -> resp_hit=0, resp_idx=0, resp_data=0x12345678, resp_valid high at T+9.
REQ-042 SHALL cover: key 0x22 in entries 1 and 6 -> resp_idx=1.
REQ-043 SHALL cover: hold resp_ready=0 for 4 cycles -> resp_valid and outputs stable, req_ready=0; release -> IDLE next cycle.
REQ-044 SHALL cover: clr together with wen to entry 0 -> all entries invalid; a lookup of that key misses.
REQ-045 SHALL cover: rst during SEARCH -> next cycle resp_valid=0, all outputs 0, previously written key misses.
